// File: rtl/mult_share_ctrl_pkg.sv
// Shared definitions for the multiplier sharing controller.
// Holds the FSM state encodings and the operand/product widths.
package mult_share_ctrl_pkg;

    localparam int unsigned OP_WIDTH   = 8;
    localparam int unsigned PROD_WIDTH = 2 * OP_WIDTH;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] MUL  = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;

endpackage

// File: rtl/mult_share_ctrl_mul.sv
// Shared 8x8 signed combinational multiplier datapath.
//   a, b : two's-complement operands
//   p    : full 16-bit two's-complement product
// Operands are converted to sign-magnitude, multiplied as an unsigned
// shift-add array, and the sign is restored on the result.
module smul8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    logic [7:0]  mag_a;
    logic [7:0]  mag_b;
    logic [15:0] acc;

    always_comb begin
        // -128 maps to magnitude 0x80, which is exact as an unsigned value
        mag_a = a[7] ? (~a + 8'd1) : a;
        mag_b = b[7] ? (~b + 8'd1) : b;
        acc   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mag_b[i]) begin
                acc = acc + (16'(mag_a) << i);
            end
        end
        p = (a[7] ^ b[7]) ? (~acc + 16'd1) : acc;
    end

endmodule

// File: rtl/mult_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter.
//   valid : request bits, bit N belongs to requester N
//   ptr   : requester favoured when both are valid
//   grant : one-hot grant (all zero when no request)
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant[ptr] = 1'b1;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Two-requester sequencer/arbiter in front of the shared signed multiplier.
// Operands and product are registered so the multiplier path is cut on both
// sides; products are returned with a requester tag over valid/ready.
//   clk, rst              : clock, synchronous active-high reset
//   reqN_valid/ready/a/b  : requester N operand handshake (N = 0, 1)
//   out_valid/ready       : product handshake
//   out_product, out_id   : signed product and issuing requester
//   busy                  : controller is not idle
//   done_cnt0/1           : saturating completion counters per requester
module mult_share_ctrl
    import mult_share_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 out_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     done_cnt0,
    output logic [CNT_W-1:0]     done_cnt1
);

    if (WIDTH != OP_WIDTH) begin : g_bad_width
        $error("mult_share_ctrl: WIDTH must be 8");
    end

    logic [1:0]            state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic                  id_q, id_d;
    logic [2*WIDTH-1:0]    prod_q, prod_d;
    logic                  out_id_q, out_id_d;
    logic [CNT_W-1:0]      cnt0_q, cnt0_d;
    logic [CNT_W-1:0]      cnt1_q, cnt1_d;
    logic [1:0]            grant;
    logic [2*WIDTH-1:0]    mul_p;

    rr_arb2 u_arb (
        .valid (({req1_valid, req0_valid})),
        .ptr   (ptr_q),
        .grant (grant)
    );

    smul8 u_mul (
        .a (a_q),
        .b (b_q),
        .p (mul_p)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        prod_d   = prod_q;
        out_id_d = out_id_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    state_d = MUL;
                    a_d     = grant[1] ? req1_a : req0_a;
                    b_d     = grant[1] ? req1_b : req0_b;
                    id_d    = grant[1];
                end
            end
            MUL: begin
                state_d  = HOLD;
                prod_d   = mul_p;
                out_id_d = id_q;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    // the requester just served loses priority
                    ptr_d   = ~out_id_q;
                    if (out_id_q) begin
                        if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            prod_q   <= '0;
            out_id_q <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            prod_q   <= prod_d;
            out_id_q <= out_id_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign req0_ready  = (state_q == IDLE) & grant[0];
    assign req1_ready  = (state_q == IDLE) & grant[1];
    assign out_valid   = (state_q == HOLD);
    assign out_product = prod_q;
    assign out_id      = out_id_q;
    assign busy        = (state_q != IDLE);
    assign done_cnt0   = cnt0_q;
    assign done_cnt1   = cnt1_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed self-checking bench for mult_share_ctrl. A second instance with
// 2-bit counters receives the same stimulus to observe counter saturation.
module tb_mult_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, out_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, out_valid, out_id, busy;
    logic [15:0] out_product, done_cnt0, done_cnt1;
    logic        s_req0_ready, s_req1_ready, s_out_valid, s_out_id, s_busy;
    logic [15:0] s_out_product;
    logic [1:0]  s_done_cnt0, s_done_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mult_share_ctrl #(.CNT_W(16), .WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .out_id(out_id), .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    mult_share_ctrl #(.CNT_W(2), .WIDTH(8)) u_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_product(s_out_product),
        .out_id(s_out_id), .busy(s_busy), .done_cnt0(s_done_cnt0), .done_cnt1(s_done_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from a lone requester with immediate accept.
    task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        check("op_ready0", 32'(req0_ready), 32'(!id));
        check("op_ready1", 32'(req1_ready), 32'(id));
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("op_mul_valid", 32'(out_valid), 32'd0);
        check("op_mul_busy", 32'(busy), 32'd1);
        tick();
        check("op_hold_valid", 32'(out_valid), 32'd1);
        check("op_product", 32'(out_product), 32'(exp));
        check("op_id", 32'(out_id), 32'(id));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("op_done_valid", 32'(out_valid), 32'd0);
        check("op_done_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cnt0"}, 32'(done_cnt0), 32'd0);
        check({tag, "_cnt1"}, 32'(done_cnt1), 32'd0);
        check({tag, "_product"}, 32'(out_product), 32'd0);
        check({tag, "_id"}, 32'(out_id), 32'd0);
        // pointer back to 0: contention must favour requester 0
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check({tag, "_ptr_r0"}, 32'(req0_ready), 32'd1);
        check({tag, "_ptr_r1"}, 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check_reset_state("rst");

        // sign mix: 5 * -3 = -15
        do_op(1'b0, 8'h05, 8'hFD, 16'hFFF1);
        check("mix_cnt0", 32'(done_cnt0), 32'd1);
        // extremes
        do_op(1'b1, 8'h80, 8'h80, 16'h4000);
        do_op(1'b1, 8'h80, 8'h7F, 16'hC080);
        check("ext_cnt1", 32'(done_cnt1), 32'd2);
        check("ext_sat_cnt1", 32'(s_done_cnt1), 32'd2);

        // contention: grants alternate starting with requester 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04;
        req1_valid = 1'b1; req1_a = 8'hFE; req1_b = 8'h07;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rr_ready0", 32'(req0_ready), 32'(k % 2 == 0));
            check("rr_ready1", 32'(req1_ready), 32'(k % 2 == 1));
            tick();
            check("rr_mul_ready", 32'({req1_ready, req0_ready}), 32'd0);
            tick();
            check("rr_id", 32'(out_id), 32'(k % 2));
            check("rr_product", 32'(out_product), (k % 2 == 0) ? 32'h000C : 32'hFFF2);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        check("rr_cnt0", 32'(done_cnt0), 32'd2);
        check("rr_cnt1", 32'(done_cnt1), 32'd2);

        // backpressure: 127 * 127 = 16129 held for 5 cycles
        req0_valid = 1'b1; req0_a = 8'h7F; req0_b = 8'h7F;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_product", 32'(out_product), 32'h3F01);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_ready", 32'({req1_ready, req0_ready}), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        req1_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_cnt0", 32'(done_cnt0), 32'd3);
        check("bp_sat_cnt0", 32'(s_done_cnt0), 32'd3);

        // reset during MUL (pointer would otherwise favour requester 1)
        req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h22;
        tick();
        req1_valid = 1'b0;
        check("rm_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst_mul");
        do_op(1'b0, 8'h0A, 8'h0A, 16'h0064);
        check("rm_cnt0", 32'(done_cnt0), 32'd1);

        // reset during HOLD discards the held product
        req1_valid = 1'b1; req1_a = 8'h02; req1_b = 8'h03;
        tick();
        req1_valid = 1'b0;
        tick();
        check("rh_valid_pre", 32'(out_valid), 32'd1);
        check("rh_product_pre", 32'(out_product), 32'h0006);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst_hold");

        // saturation on the 2-bit instance: -1 * -1 = 1, five times
        for (int n = 1; n <= 5; n++) begin
            do_op(1'b0, 8'hFF, 8'hFF, 16'h0001);
            check("sat_cnt0", 32'(s_done_cnt0), (n < 3) ? 32'(n) : 32'd3);
            check("wide_cnt0", 32'(done_cnt0), 32'(n));
        end
        check("sat_cnt1", 32'(s_done_cnt1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
